// File: rtl/pea_alu_lanes.sv
// PSI-lane modular ALU with a fixed 4-stage pipeline feeding a DEPTH-entry output buffer.
// Flow control counts in-flight plus buffered beats, so the buffer can never overflow.
package hpu_common_instruction_pkg;
    localparam int unsigned DOP_W     = 5;
    localparam int unsigned MSG_CST_W = 8;

    localparam logic [DOP_W-1:0] DOP_ADD  = 5'h00;
    localparam logic [DOP_W-1:0] DOP_SUB  = 5'h01;
    localparam logic [DOP_W-1:0] DOP_MAC  = 5'h02;
    localparam logic [DOP_W-1:0] DOP_MULS = 5'h03;
    localparam logic [DOP_W-1:0] DOP_ADDS = 5'h04;
    localparam logic [DOP_W-1:0] DOP_SUBS = 5'h05;
    localparam logic [DOP_W-1:0] DOP_SSUB = 5'h06;
endpackage

module pea_alu_lanes
    import hpu_common_instruction_pkg::*;
#(
    parameter int unsigned PSI          = 4,
    parameter int unsigned MOD_Q_W      = 64,
    parameter int unsigned USEFUL_BIT   = 5,
    parameter int unsigned MUL_FACTOR_W = 8,
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned SIDE_W       = 1
) (
    input  logic                    clk,
    input  logic                    a_rst,
    input  logic [PSI*MOD_Q_W-1:0]  in_a0,
    input  logic [PSI*MOD_Q_W-1:0]  in_a1,
    input  logic [PSI-1:0]          in_body_mask,
    input  logic [DOP_W-1:0]        in_dop,
    input  logic [MSG_CST_W-1:0]    in_msg_cst,
    input  logic [MUL_FACTOR_W-1:0] in_mul_factor,
    input  logic [SIDE_W-1:0]       in_side,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [PSI*MOD_Q_W-1:0]  out_z,
    output logic [SIDE_W-1:0]       out_side,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    err_dop
);
    localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    localparam int unsigned PROD_W = MOD_Q_W + MUL_FACTOR_W;
    localparam int unsigned PAD_W  = MOD_Q_W - USEFUL_BIT;

    typedef logic [PSI-1:0][MOD_Q_W-1:0] lanes_t;

    lanes_t a0_l, a1_l, y_l;
    logic   dec_mul, dec_sub, dec_rev, dec_zero, dec_use_a1, dec_use_cst;
    logic   accept, pop, wr;
    logic   unused_cst;

    lanes_t                   s1_a0_q, s1_y_q;
    logic [MUL_FACTOR_W-1:0]  s1_f_q;
    logic                     s1_mul_q, s1_sub_q, s1_rev_q, s1_zero_q;
    logic [SIDE_W-1:0]        s1_side_q;
    lanes_t                   s2_x_d, s2_x_q, s2_y_q;
    logic                     s2_sub_q, s2_rev_q, s2_zero_q;
    logic [SIDE_W-1:0]        s2_side_q;
    lanes_t                   s3_z_d, s3_z_q;
    logic                     s3_zero_q;
    logic [SIDE_W-1:0]        s3_side_q;
    lanes_t                   s4_z_q;
    logic [SIDE_W-1:0]        s4_side_q;

    lanes_t                   mem_z_q    [DEPTH];
    logic [SIDE_W-1:0]        mem_side_q [DEPTH];

    logic [3:0]               vld_d, vld_q;
    logic [CNT_W-1:0]         occ_d, occ_q, buf_cnt_d, buf_cnt_q;
    logic [PTR_W-1:0]         wr_ptr_d, wr_ptr_q, rd_ptr_d, rd_ptr_q;
    logic                     in_ready_d, in_ready_q, out_valid_d, out_valid_q, err_d, err_q;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign a0_l       = in_a0;
    assign a1_l       = in_a1;
    assign accept     = in_valid && in_ready_q;
    assign pop        = out_valid_q && out_ready;
    assign wr         = vld_q[3];
    assign unused_cst = ^in_msg_cst;

    // Opcode decode into multiply / addend-select / subtract-direction controls
    always_comb begin
        dec_mul     = 1'b0;
        dec_sub     = 1'b0;
        dec_rev     = 1'b0;
        dec_zero    = 1'b0;
        dec_use_a1  = 1'b0;
        dec_use_cst = 1'b0;
        case (in_dop)
            DOP_ADD:  dec_use_a1 = 1'b1;
            DOP_SUB:  begin dec_use_a1 = 1'b1; dec_sub = 1'b1; end
            DOP_MAC:  begin dec_use_a1 = 1'b1; dec_mul = 1'b1; end
            DOP_MULS: dec_mul = 1'b1;
            DOP_ADDS: dec_use_cst = 1'b1;
            DOP_SUBS: begin dec_use_cst = 1'b1; dec_sub = 1'b1; end
            DOP_SSUB: begin dec_use_cst = 1'b1; dec_rev = 1'b1; end
            default:  dec_zero = 1'b1;
        endcase
    end

    always_comb begin
        y_l = '0;
        for (int i = 0; i < PSI; i++) begin
            if (dec_use_a1)
                y_l[i] = a1_l[i];
            else if (dec_use_cst && in_body_mask[i])
                y_l[i] = {in_msg_cst[USEFUL_BIT-1:0], PAD_W'(0)};
        end
    end

    always_comb begin
        s2_x_d = s1_a0_q;
        if (s1_mul_q) begin
            for (int i = 0; i < PSI; i++)
                s2_x_d[i] = MOD_Q_W'(PROD_W'(s1_a0_q[i]) * PROD_W'(s1_f_q));
        end
    end

    always_comb begin
        s3_z_d = '0;
        for (int i = 0; i < PSI; i++) begin
            if (s2_rev_q)      s3_z_d[i] = s2_y_q[i] - s2_x_q[i];
            else if (s2_sub_q) s3_z_d[i] = s2_x_q[i] - s2_y_q[i];
            else               s3_z_d[i] = s2_x_q[i] + s2_y_q[i];
        end
    end

    // Pipeline and buffer data; validity lives in the reset-controlled registers below
    always_ff @(posedge clk) begin
        if (accept) begin
            s1_a0_q   <= a0_l;
            s1_y_q    <= y_l;
            s1_f_q    <= in_mul_factor;
            s1_mul_q  <= dec_mul;
            s1_sub_q  <= dec_sub;
            s1_rev_q  <= dec_rev;
            s1_zero_q <= dec_zero;
            s1_side_q <= in_side;
        end
        s2_x_q    <= s2_x_d;
        s2_y_q    <= s1_y_q;
        s2_sub_q  <= s1_sub_q;
        s2_rev_q  <= s1_rev_q;
        s2_zero_q <= s1_zero_q;
        s2_side_q <= s1_side_q;
        s3_z_q    <= s3_z_d;
        s3_zero_q <= s2_zero_q;
        s3_side_q <= s2_side_q;
        s4_z_q    <= s3_zero_q ? '0 : s3_z_q;
        s4_side_q <= s3_side_q;
        if (wr) begin
            mem_z_q[wr_ptr_q]    <= s4_z_q;
            mem_side_q[wr_ptr_q] <= s4_side_q;
        end
    end

    always_comb begin
        vld_d       = {vld_q[2:0], accept};
        occ_d       = occ_q + CNT_W'(accept) - CNT_W'(pop);
        buf_cnt_d   = buf_cnt_q + CNT_W'(wr) - CNT_W'(pop);
        wr_ptr_d    = wr ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d    = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        in_ready_d  = occ_d < CNT_W'(DEPTH);
        out_valid_d = buf_cnt_d != '0;
        err_d       = err_q | (accept & dec_zero);
    end

    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            vld_q       <= '0;
            occ_q       <= '0;
            buf_cnt_q   <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            vld_q       <= vld_d;
            occ_q       <= occ_d;
            buf_cnt_q   <= buf_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign err_dop   = err_q;
    assign out_z     = mem_z_q[rd_ptr_q];
    assign out_side  = mem_side_q[rd_ptr_q];

endmodule

// File: tb/tb_pea_alu_lanes.sv
// Randomized bench for pea_alu_lanes: every beat is scored against modular lane arithmetic,
// with expected valid/ready timing derived from accept times and occupancy.
module tb_pea_alu_lanes;
    import hpu_common_instruction_pkg::*;

    localparam int unsigned PSI   = 4;
    localparam int unsigned QW    = 16;
    localparam int unsigned UB    = 4;
    localparam int unsigned FW    = 8;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned SW    = 4;
    localparam int unsigned ZW    = PSI * QW;
    localparam logic [DOP_W-1:0] DOP_BAD = 5'h1F;

    logic                 clk = 1'b0;
    logic                 a_rst;
    logic [ZW-1:0]        in_a0, in_a1;
    logic [PSI-1:0]       in_body_mask;
    logic [DOP_W-1:0]     in_dop;
    logic [MSG_CST_W-1:0] in_msg_cst;
    logic [FW-1:0]        in_mul_factor;
    logic [SW-1:0]        in_side;
    logic                 in_valid, in_ready;
    logic [ZW-1:0]        out_z;
    logic [SW-1:0]        out_side;
    logic                 out_valid, out_ready;
    logic                 err_dop;

    typedef struct {
        logic [ZW-1:0] z;
        logic [SW-1:0] side;
        int            t;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   n_acc   = 0;
    int   n0;
    bit   model_err = 1'b0;
    bit   rdy_arm   = 1'b0;

    always #5 clk = ~clk;

    pea_alu_lanes #(
        .PSI(PSI), .MOD_Q_W(QW), .USEFUL_BIT(UB),
        .MUL_FACTOR_W(FW), .DEPTH(DEPTH), .SIDE_W(SW)
    ) dut (
        .clk(clk), .a_rst(a_rst),
        .in_a0(in_a0), .in_a1(in_a1), .in_body_mask(in_body_mask),
        .in_dop(in_dop), .in_msg_cst(in_msg_cst), .in_mul_factor(in_mul_factor),
        .in_side(in_side), .in_valid(in_valid), .in_ready(in_ready),
        .out_z(out_z), .out_side(out_side), .out_valid(out_valid),
        .out_ready(out_ready), .err_dop(err_dop)
    );

    task automatic check(input string tag, input logic [ZW-1:0] got, input logic [ZW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [ZW-1:0] ref_beat(input logic [DOP_W-1:0] op,
                                               input logic [ZW-1:0] a0, input logic [ZW-1:0] a1,
                                               input logic [PSI-1:0] mask, input logic [MSG_CST_W-1:0] cst,
                                               input logic [FW-1:0] f);
        logic [ZW-1:0]   z;
        longint unsigned x, y, c, r, m;
        m = 64'd1 << QW;
        z = '0;
        for (int i = 0; i < PSI; i++) begin
            x = 64'(a0[i*QW +: QW]);
            y = 64'(a1[i*QW +: QW]);
            c = mask[i] ? (64'(cst) % (64'd1 << UB)) << (QW - UB) : 64'd0;
            case (op)
                DOP_ADD:  r = x + y;
                DOP_SUB:  r = x + m - y;
                DOP_MAC:  r = x * 64'(f) + y;
                DOP_MULS: r = x * 64'(f);
                DOP_ADDS: r = x + c;
                DOP_SUBS: r = x + m - c;
                DOP_SSUB: r = c + m - x;
                default:  r = 64'd0;
            endcase
            z[i*QW +: QW] = QW'(r % m);
        end
        return z;
    endfunction

    // One clock: score at the falling edge, then step past the rising edge
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (a_rst) begin
            check("rst_in_ready", ZW'(in_ready), '0);
            check("rst_out_valid", ZW'(out_valid), '0);
            check("rst_err_dop", ZW'(err_dop), '0);
            exp_q.delete();
            model_err = 1'b0;
            rdy_arm   = 1'b0;
        end else begin
            check("out_valid", ZW'(out_valid), ZW'(exp_q.size() != 0 && exp_q[0].t <= cyc));
            check("in_ready", ZW'(in_ready), ZW'(rdy_arm && exp_q.size() < int'(DEPTH)));
            check("err_dop", ZW'(err_dop), ZW'(model_err));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_beat", ZW'(out_valid), '0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_z", out_z, e.z);
                    check("out_side", ZW'(out_side), ZW'(e.side));
                end
            end
            if (in_valid && in_ready) begin
                e.z    = ref_beat(in_dop, in_a0, in_a1, in_body_mask, in_msg_cst, in_mul_factor);
                e.side = in_side;
                e.t    = cyc + 5;
                exp_q.push_back(e);
                n_acc++;
                if (!(in_dop inside {DOP_ADD, DOP_SUB, DOP_MAC, DOP_MULS, DOP_ADDS, DOP_SUBS, DOP_SSUB}))
                    model_err = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (!a_rst) rdy_arm = 1'b1;
    endtask

    task automatic drive(input logic v, input logic [DOP_W-1:0] op, input logic [ZW-1:0] a0,
                         input logic [ZW-1:0] a1, input logic [PSI-1:0] m,
                         input logic [MSG_CST_W-1:0] c, input logic [FW-1:0] f, input logic [SW-1:0] s);
        in_valid      = v;
        in_dop        = op;
        in_a0         = a0;
        in_a1         = a1;
        in_body_mask  = m;
        in_msg_cst    = c;
        in_mul_factor = f;
        in_side       = s;
    endtask

    task automatic rand_drive(input logic v);
        logic [DOP_W-1:0] op;
        logic [ZW-1:0]    a0, a1;
        int               k;
        k = $urandom_range(0, 42);
        case (k % 7)
            0: op = DOP_ADD;
            1: op = DOP_SUB;
            2: op = DOP_MAC;
            3: op = DOP_MULS;
            4: op = DOP_ADDS;
            5: op = DOP_SUBS;
            default: op = DOP_SSUB;
        endcase
        if (k == 42) op = DOP_BAD;
        a0 = {$urandom, $urandom};
        a1 = {$urandom, $urandom};
        if ($urandom_range(0, 7) == 0) a0 = '1;
        drive(v, op, a0, a1, PSI'($urandom), MSG_CST_W'($urandom), FW'($urandom), SW'($urandom));
    endtask

    task automatic directed(input string tag, input logic [DOP_W-1:0] op, input logic [ZW-1:0] a0,
                            input logic [ZW-1:0] a1, input logic [PSI-1:0] m,
                            input logic [MSG_CST_W-1:0] c, input logic [FW-1:0] f,
                            input logic [ZW-1:0] exp_z);
        bit seen;
        seen      = 1'b0;
        out_ready = 1'b1;
        drive(1'b1, op, a0, a1, m, c, f, SW'(5));
        tick();
        in_valid = 1'b0;
        for (int k = 1; k <= 8 && !seen; k++) begin
            tick();
            if (out_valid) begin
                seen = 1'b1;
                check({tag, "_latency"}, ZW'(k), ZW'(4));
                check(tag, out_z, exp_z);
            end
        end
        if (!seen) check({tag, "_timeout"}, ZW'(out_valid), ZW'(1));
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        a_rst     = 1'b1;
        out_ready = 1'b0;
        drive(1'b0, DOP_ADD, '0, '0, '0, '0, '0, '0);
        repeat (3) tick();
        a_rst = 1'b0;
        check("rdy_before_edge", ZW'(in_ready), '0);
        tick();
        check("rdy_after_reset", ZW'(in_ready), ZW'(1));

        directed("add_wrap", DOP_ADD, {4{16'hFFFF}}, {4{16'h0002}}, 4'b0000, 8'h00, 8'h00,
                 {4{16'h0001}});
        directed("ssub_body", DOP_SSUB, {4{16'h0001}}, {4{16'hABCD}}, 4'b0001, 8'h03, 8'h00,
                 {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h2FFF});
        directed("mac_wrap", DOP_MAC, {4{16'h1000}}, {4{16'h0005}}, 4'b0000, 8'h00, 8'h10,
                 {4{16'h0005}});

        // Illegal opcode sandwiched between two ADDs
        check("err_before", ZW'(err_dop), '0);
        out_ready = 1'b1;
        drive(1'b1, DOP_ADD, {4{16'h0100}}, {4{16'h0023}}, 4'hF, 8'h0F, 8'h02, SW'(1));
        tick();
        drive(1'b1, DOP_BAD, {4{16'hFFFF}}, {4{16'hFFFF}}, 4'hF, 8'h0F, 8'h02, SW'(2));
        tick();
        check("err_set", ZW'(err_dop), ZW'(1));
        drive(1'b1, DOP_ADD, {4{16'h8000}}, {4{16'h8001}}, 4'hF, 8'h0F, 8'h02, SW'(3));
        tick();
        in_valid = 1'b0;
        repeat (8) tick();
        check("err_sticky", ZW'(err_dop), ZW'(1));

        // Fill with output stalled, then drain in order
        out_ready = 1'b0;
        n0 = n_acc;
        repeat (14) begin
            rand_drive(1'b1);
            tick();
        end
        check("fill_count", ZW'(n_acc - n0), ZW'(DEPTH));
        check("fill_ready_low", ZW'(in_ready), '0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("ready_after_pop", ZW'(in_ready), ZW'(1));
        repeat (10) tick();
        check("fill_drained", ZW'(exp_q.size()), '0);

        // Streaming with out_ready held high must accept every cycle
        n0 = n_acc;
        repeat (200) begin
            rand_drive(1'b1);
            tick();
        end
        check("throughput", ZW'(n_acc - n0), ZW'(200));
        in_valid = 1'b0;
        repeat (12) tick();

        // Reset with three beats in flight
        repeat (3) begin
            rand_drive(1'b1);
            tick();
        end
        in_valid = 1'b0;
        a_rst    = 1'b1;
        #1;
        check("midrst_out_valid", ZW'(out_valid), '0);
        check("midrst_in_ready", ZW'(in_ready), '0);
        repeat (2) tick();
        a_rst = 1'b0;
        tick();
        check("midrst_ready_back", ZW'(in_ready), ZW'(1));
        repeat (8) tick();
        check("no_stale_beats", ZW'(out_valid), '0);
        directed("post_reset", DOP_ADD, {4{16'h1234}}, {4{16'h1111}}, 4'b0000, 8'h00, 8'h00,
                 {4{16'h2345}});

        // Random traffic with random backpressure
        repeat (1500) begin
            rand_drive($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (15) tick();
        check("final_drain", ZW'(exp_q.size()), '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pea_alu_lanes.md
PEA_ALU_LANES -- requirements
Module: pea_alu_lanes

Interface
REQ-001 SHALL have parameter PSI, default 4, number of coefficient lanes processed per beat.
REQ-002 SHALL have parameter MOD_Q_W, default 64, coefficient width; modulus is 2^MOD_Q_W.
REQ-003 SHALL have parameter USEFUL_BIT, default 5, message bits placed in the MSBs of a body coefficient.
REQ-004 SHALL have parameter MUL_FACTOR_W, default 8, scalar multiplier width.
REQ-005 SHALL have parameter DEPTH, default 8, output buffer depth (>= 4).
REQ-006 SHALL have parameter SIDE_W, default 1, side-band width carried with each beat.
REQ-007 SHALL have port clk  input  1  clock; one clock, all logic on the rising edge.
REQ-008 SHALL have port a_rst  input  1  reset, asynchronous, active-high.
REQ-009 SHALL have port in_a0  input  PSI*MOD_Q_W  operand 0, lane i at bits [i*MOD_Q_W +: MOD_Q_W].
REQ-010 SHALL have port in_a1  input  PSI*MOD_Q_W  operand 1, same lane packing.
REQ-011 SHALL have port in_body_mask  input  PSI  lane carries the body coefficient.
REQ-012 SHALL have port in_dop  input  DOP_W  opcode, from hpu_common_instruction_pkg.
REQ-013 SHALL have port in_msg_cst  input  MSG_CST_W  message constant.
REQ-014 SHALL have port in_mul_factor  input  MUL_FACTOR_W  scalar.
REQ-015 SHALL have port in_side  input  SIDE_W  side-band.
REQ-016 SHALL have port in_valid / in_ready  input / output  1 / 1  input handshake.
REQ-017 SHALL have port out_z  output  PSI*MOD_Q_W  results, same lane packing.
REQ-018 SHALL have port out_side  output  SIDE_W  side-band of the beat.
REQ-019 SHALL have port out_valid / out_ready  output / input  1 / 1  output handshake.
REQ-020 SHALL have port err_dop  output  1  sticky illegal-opcode flag.

Function
REQ-021 SHALL accept a beat when in_valid && in_ready.
REQ-022 SHALL output a beat when out_valid && out_ready; beats leave in acceptance order.
REQ-023 SHALL compute per lane the constant cst_i = in_body_mask[i] ? in_msg_cst[USEFUL_BIT-1:0] << (MOD_Q_W-USEFUL_BIT) : 0.
REQ-024 SHALL compute per lane, mod 2^MOD_Q_W: ADD a0+a1; SUB a0-a1; MAC a0*f+a1; MULS a0*f; ADDS a0+cst; SUBS a0-cst; SSUB cst-a0 (f = in_mul_factor).
REQ-025 SHALL, for any other opcode, produce zero on all lanes, keep side-band, and set err_dop; err_dop clears only on reset.
REQ-026 SHALL use a fixed 4-stage pipeline for every opcode (operand select, multiply, add/sub, result register), so a beat is written into the output buffer exactly 4 cycles after acceptance.
REQ-027 SHALL maintain an occupancy counter (in-flight + buffered beats): +1 on accept, -1 on output pop, unchanged when both occur in the same cycle.
REQ-028 SHALL drive in_ready = (occupancy < DEPTH), derived from registered state only; it never depends combinationally on out_ready.
REQ-029 SHALL drive out_valid = buffer non-empty, with out_z/out_side from the buffer head and stable while out_valid && !out_ready.
REQ-030 SHALL support full throughput (one accept and one pop per cycle) when out_ready is held high.
REQ-031 SHALL, at occupancy == DEPTH, hold in_ready low even when a pop occurs that cycle; in_ready rises the following cycle.
REQ-032 SHALL wrap buffer read/write pointers modulo DEPTH, with no loss or duplication at wrap.
REQ-033 SHALL ignore in_* data when in_valid is low, and hold the pipeline-stage valid bits low for that beat.

Reset
REQ-034 SHALL, while a_rst is high, force in_ready=0, out_valid=0, err_dop=0, occupancy=0, pointers=0 and all stage valids=0; data registers need no reset.
REQ-035 SHALL discard all in-flight and buffered beats on reset mid-operation; in_ready=1 on the first clk edge after a_rst falls.

Verification
REQ-036 SHALL pass: PSI=4, MOD_Q_W=16, USEFUL_BIT=4; ADD with lane a0=0xFFFF, a1=0x0002 -> lane z=0x0001, out_valid 4 cycles after accept.
REQ-037 SHALL pass: SSUB, msg_cst=3, body_mask=4'b0001, a0=1 on all lanes -> lane0 z=0x2FFF, lanes1-3 z=0xFFFF.
REQ-038 SHALL pass: MAC, a0=0x1000, f=0x10, a1=5 -> z=0x0005 (product wraps).
REQ-039 SHALL pass: DEPTH=8, out_ready=0, in_valid held 1 -> exactly 8 beats accepted, in_ready low; then out_ready=1 -> 8 beats out in order, in_ready high one cycle after first pop.
REQ-040 SHALL pass: illegal opcode beat between two ADDs -> zero result beat, err_dop=1 from that point, neighbouring ADD results correct.
REQ-041 SHALL pass: a_rst pulsed with 3 beats in flight -> out_valid=0, no stale beats emerge, next accepted beat emerges correctly 4 cycles later.
